// File: rtl/script_sequencer_pkg.sv
// script_sequencer_pkg: opcodes, jump/wait func codes, FSM states and word fields
// shared by the sequencer and the script analyser.
package script_sequencer_pkg;
   localparam logic [2:0] OP_END = 3'b000, OP_ACTION = 3'b001, OP_JUMP = 3'b010, OP_WAIT = 3'b011, OP_GAME = 3'b100;
   localparam logic [1:0] JMP_ALWAYS = 2'b00, JMP_IF_SET = 2'b01, JMP_IF_CLR = 2'b10, JMP_NEVER = 2'b11;
   localparam logic [1:0] WAIT_TIMED = 2'b00, WAIT_COND = 2'b01;
   localparam int I_NUM_HI = 15, I_NUM_LO = 8, I_SIGN_HI = 7, I_SIGN_LO = 5;
   localparam int FUNC_HI = 4, FUNC_LO = 3, OP_HI = 2, OP_LO = 0;
   localparam int I_NUM_W = I_NUM_HI - I_NUM_LO + 1;
   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_DISPATCH, S_WAIT, S_HALT} state_t;
   function automatic logic jump_taken(logic [1:0] func, logic fb);
      return func != JMP_NEVER && (func == JMP_ALWAYS || (func == JMP_IF_SET && fb) || (func == JMP_IF_CLR && !fb));
   endfunction
endpackage

// File: rtl/script_sequencer_if.sv
// script_sequencer_if: control, script-memory and dispatch signals of the sequencer;
// master is the sequencer side, slave the memory/analyser/kitchen side.
interface script_sequencer_if #(parameter int ADDR_W = 8);
   logic start, step_done, feedback_sig;
   logic [ADDR_W-1:0] mem_addr, pc;
   logic [15:0] mem_data, script;
   logic script_valid, running, halted, error;
   modport master (
      input start, step_done, feedback_sig, mem_data,
      output mem_addr, pc, script, script_valid, running, halted, error
   );
   modport slave (
      output start, step_done, feedback_sig, mem_data,
      input mem_addr, pc, script, script_valid, running, halted, error
   );
endinterface

// File: rtl/script_sequencer_wait_timer.sv
// seq_wait_timer: WAIT_TICK-cycle prescaler feeding a unit down-counter; done marks the
// final cycle of a load-time count of units*WAIT_TICK counting cycles.
module seq_wait_timer import script_sequencer_pkg::*; #(
   parameter int WAIT_TICK = 100000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic               count,
   input  logic [I_NUM_W-1:0] units,
   output logic               done
);
   localparam int PW = WAIT_TICK > 1 ? $clog2(WAIT_TICK) : 1;
   logic [PW-1:0] presc;
   logic [I_NUM_W-1:0] left;
   logic tick;
   assign tick = presc == PW'(WAIT_TICK - 1);
   assign done = count && tick && left == I_NUM_W'(1);
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         presc <= '0;
         left <= '0;
      end else if (load) begin
         presc <= '0;
         left <= units;
      end else if (count) begin
         presc <= tick ? '0 : presc + 1'b1;
         if (tick) left <= left - 1'b1;
      end
endmodule

// File: rtl/script_sequencer.sv
// script_sequencer: fetches script words, resolves jumps/waits locally and dispatches
// action/game words one at a time; SEQ_WATCHDOG_EN adds a dispatch timeout that sets error.
module script_sequencer import script_sequencer_pkg::*; #(
   parameter int ADDR_W = 8,
   parameter int WAIT_TICK = 100000,
   parameter int WDOG_CYCLES = 2**24
) (
   input logic clk,
   input logic rst,
   script_sequencer_if.master bus
);
   state_t state, nxt;
   logic [ADDR_W-1:0] pc;
   logic [15:0] script, word;
   logic [I_NUM_W-1:0] i_num;
   logic [1:0] func;
   logic [2:0] op;
   logic wait_cond, start_ok, is_disp, wait_go, tmr_done, wdog_trip, unused;
   assign word = bus.mem_data;
   assign i_num = word[I_NUM_HI:I_NUM_LO];
   assign func = word[FUNC_HI:FUNC_LO];
   assign op = word[OP_HI:OP_LO];
   assign unused = ^{word[I_SIGN_HI:I_SIGN_LO], 32'(WDOG_CYCLES)};
   assign start_ok = bus.start && (state == S_IDLE || state == S_HALT);
   assign is_disp = op == OP_ACTION || op == OP_GAME;
   assign wait_go = func == WAIT_TIMED ? |i_num : func == WAIT_COND;
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= S_IDLE;
      else state <= nxt;
   always_comb begin
      nxt = state;
      case (state)
         S_IDLE, S_HALT: nxt = start_ok ? S_FETCH : state;
         S_FETCH:        nxt = S_DECODE;
         S_DECODE:       nxt = is_disp ? S_DISPATCH : op == OP_END ? S_HALT : (op == OP_WAIT && wait_go) ? S_WAIT : S_FETCH;
         S_DISPATCH:     nxt = bus.step_done ? S_FETCH : wdog_trip ? S_HALT : S_DISPATCH;
         S_WAIT:         nxt = (wait_cond ? bus.feedback_sig : tmr_done) ? S_FETCH : S_WAIT;
         default:        nxt = S_IDLE;
      endcase
   end
   always_comb begin
      bus.script_valid = state == S_DISPATCH;
      bus.running = state != S_IDLE && state != S_HALT;
      bus.halted = state == S_HALT;
   end
   // every transition into FETCH from a working state advances pc, unless a jump is taken
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         pc <= '0;
         script <= '0;
         wait_cond <= 1'b0;
      end else begin
         if (start_ok) pc <= '0;
         else if (state == S_DECODE && op == OP_JUMP && jump_taken(func, bus.feedback_sig)) pc <= ADDR_W'(i_num);
         else if (nxt == S_FETCH && state != S_FETCH) pc <= pc + 1'b1;
         if (state == S_DECODE && is_disp) script <= word;
         if (state == S_DECODE) wait_cond <= func == WAIT_COND;
      end
   assign bus.mem_addr = pc;
   assign bus.pc = pc;
   assign bus.script = script;
   seq_wait_timer #(.WAIT_TICK(WAIT_TICK)) u_timer (
      .clk(clk), .rst(rst), .load(state == S_DECODE), .count(state == S_WAIT && !wait_cond),
      .units(i_num), .done(tmr_done)
   );
`ifdef SEQ_WATCHDOG_EN
   localparam int WW = $clog2(WDOG_CYCLES) + 1;
   logic [WW-1:0] wdog_cnt;
   logic err;
   assign wdog_trip = state == S_DISPATCH && !bus.step_done && wdog_cnt == WW'(WDOG_CYCLES - 1);
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wdog_cnt <= '0;
         err <= 1'b0;
      end else begin
         wdog_cnt <= state == S_DISPATCH ? wdog_cnt + 1'b1 : '0;
         if (start_ok) err <= 1'b0;
         else if (wdog_trip) err <= 1'b1;
      end
   assign bus.error = err;
`else
   assign wdog_trip = 1'b0;
   assign bus.error = 1'b0;
`endif
endmodule

// File: tb/tb_script_sequencer.sv
// tb_script_sequencer: scenario tasks with a dispatch scoreboard for script_sequencer.
module tb_script_sequencer;
   import script_sequencer_pkg::*;
   logic clk = 0, rst = 0;
   logic [15:0] mem [256];
   logic [15:0] exp_q [$];
   logic [15:0] exp_w;
   logic sv_prev = 0;
   int n_checks = 0, n_fail = 0;
   script_sequencer_if #(.ADDR_W(8)) sif();
   script_sequencer #(.ADDR_W(8), .WAIT_TICK(4), .WDOG_CYCLES(16)) dut (.clk(clk), .rst(rst), .bus(sif));
   always #5 clk = ~clk;
   always @(posedge clk) sif.mem_data <= mem[sif.mem_addr];
   always @(negedge clk) begin
      if (sif.script_valid === 1'b1 && !sv_prev) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL dispatch_unexpected got %h want none", sif.script);
         end else begin
            exp_w = exp_q.pop_front();
            if (sif.script !== exp_w) begin
               n_fail++;
               $display("FAIL dispatch_word got %h want %h", sif.script, exp_w);
            end
         end
      end
      sv_prev = sif.script_valid === 1'b1;
   end
   initial begin
      #200000;
      $display("FAIL global_timeout got running want finished");
      $fatal(1, "timeout");
   end
   task automatic pulse_start();
      @(negedge clk) sif.start = 1;
      @(negedge clk) sif.start = 0;
   endtask
   task automatic clear_mem();
      foreach (mem[i]) mem[i] = '0;
   endtask
   task automatic wait_halt(output bit ok);
      ok = 0;
      repeat (200) if (!ok) begin if (sif.halted) ok = 1; else @(negedge clk); end
   endtask
   task automatic wait_valid(output bit ok);
      ok = 0;
      repeat (200) if (!ok) begin if (sif.script_valid) ok = 1; else @(negedge clk); end
   endtask
   task automatic test_reset();
      sif.start = 0; sif.step_done = 0; sif.feedback_sig = 0;
      clear_mem();
      #1 rst = 1;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({sif.script_valid, sif.running, sif.halted, sif.error} !== 4'b0) begin
         n_fail++; $display("FAIL reset_flags got %b want 0000", {sif.script_valid, sif.running, sif.halted, sif.error});
      end
      n_checks++;
      if ({sif.pc, sif.mem_addr, sif.script} !== 32'h0) begin
         n_fail++; $display("FAIL reset_data got %h want 0", {sif.pc, sif.mem_addr, sif.script});
      end
      rst = 0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (sif.running !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset got %b want 0", sif.running); end
   endtask
   task automatic test_action();
      bit ok;
      clear_mem();
      mem[0] = 16'h0301;
      exp_q.push_back(16'h0301);
      pulse_start();
      n_checks++;
      if ({sif.running, sif.script_valid, sif.pc} !== {2'b10, 8'd0}) begin
         n_fail++; $display("FAIL action_fetch got %b/%b/%h want 1/0/00", sif.running, sif.script_valid, sif.pc);
      end
      @(negedge clk);
      n_checks++;
      if (sif.script_valid !== 1'b0) begin n_fail++; $display("FAIL action_decode_valid got %b want 0", sif.script_valid); end
      @(negedge clk);
      n_checks++;
      if (sif.script_valid !== 1'b1) begin n_fail++; $display("FAIL action_k3_valid got %b want 1", sif.script_valid); end
      @(negedge clk) sif.step_done = 1;
      @(negedge clk) sif.step_done = 0;
      n_checks++;
      if ({sif.script_valid, sif.pc} !== {1'b0, 8'd1}) begin
         n_fail++; $display("FAIL action_step_done got %b/%h want 0/01", sif.script_valid, sif.pc);
      end
      wait_halt(ok);
      n_checks++;
      if (!ok || {sif.halted, sif.running, sif.pc, sif.script} !== {2'b10, 8'd1, 16'h0301}) begin
         n_fail++; $display("FAIL action_halt got %b/%b/%h/%h want 1/0/01/0301", sif.halted, sif.running, sif.pc, sif.script);
      end
   endtask
   task automatic test_jump();
      bit ok;
      logic [1:0] fn_t [6] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b11};
      logic fb_t [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [7:0] pc_t [6] = '{8'd5, 8'd5, 8'd1, 8'd5, 8'd1, 8'd1};
      for (int i = 0; i < 6; i++) begin
         clear_mem();
         mem[0] = {8'd5, 3'b000, fn_t[i], OP_JUMP};
         sif.feedback_sig = fb_t[i];
         pulse_start();
         @(negedge clk);
         @(negedge clk);
         n_checks++;
         if (sif.pc !== pc_t[i]) begin n_fail++; $display("FAIL jump_pc[%0d] got %h want %h", i, sif.pc, pc_t[i]); end
         wait_halt(ok);
         n_checks++;
         if (!ok || sif.pc !== pc_t[i]) begin n_fail++; $display("FAIL jump_halt[%0d] got %b/%h want 1/%h", i, ok, sif.pc, pc_t[i]); end
      end
      sif.feedback_sig = 0;
   endtask
   task automatic test_wait_timed();
      bit ok;
      int n;
      logic [15:0] w_t [6] = '{16'h0303, 16'h0003, 16'h0103, 16'h0013, 16'h0203, 16'h001B};
      int n_t [6] = '{14, 2, 6, 2, 10, 2};
      for (int i = 0; i < 6; i++) begin
         clear_mem();
         mem[0] = w_t[i];
         pulse_start();
         n = 0;
         while (sif.pc == 8'd0 && n < 100) begin n++; @(negedge clk); end
         n_checks++;
         if (n != n_t[i] || sif.pc !== 8'd1) begin
            n_fail++; $display("FAIL wait_cycles[%h] got %0d pc %h want %0d pc 01", w_t[i], n, sif.pc, n_t[i]);
         end
         wait_halt(ok);
      end
   endtask
   task automatic test_wait_feedback();
      bit ok;
      clear_mem();
      mem[0] = 16'h000B;
      sif.feedback_sig = 0;
      pulse_start();
      repeat (18) @(negedge clk);
      n_checks++;
      if ({sif.pc, sif.running} !== {8'd0, 1'b1}) begin
         n_fail++; $display("FAIL wait_fb_hold got %h/%b want 00/1", sif.pc, sif.running);
      end
      @(negedge clk) sif.feedback_sig = 1;
      @(negedge clk) sif.feedback_sig = 0;
      n_checks++;
      if (sif.pc !== 8'd1) begin n_fail++; $display("FAIL wait_fb_release got %h want 01", sif.pc); end
      wait_halt(ok);
   endtask
   task automatic test_wrap();
      bit ok;
      clear_mem();
      mem[0] = 16'hFF0A;
      mem[255] = 16'h0007;
      sif.feedback_sig = 1;
      pulse_start();
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (sif.pc !== 8'hFF) begin n_fail++; $display("FAIL wrap_jump got %h want ff", sif.pc); end
      sif.feedback_sig = 0;
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if ({sif.pc, sif.mem_addr} !== 16'h0000) begin
         n_fail++; $display("FAIL wrap_pc got %h/%h want 00/00", sif.pc, sif.mem_addr);
      end
      wait_halt(ok);
      n_checks++;
      if (!ok || sif.pc !== 8'd1) begin n_fail++; $display("FAIL wrap_halt got %b/%h want 1/01", ok, sif.pc); end
   endtask
   task automatic test_back_to_back();
      bit ok;
      logic [15:0] w_t [4] = '{16'h0301, 16'h1204, 16'h0001, 16'h7F21};
      clear_mem();
      for (int i = 0; i < 4; i++) begin mem[i] = w_t[i]; exp_q.push_back(w_t[i]); end
      pulse_start();
      for (int i = 0; i < 4; i++) begin
         wait_valid(ok);
         n_checks++;
         if (!ok) begin n_fail++; $display("FAIL b2b_valid_timeout[%0d] got 0 want 1", i); end
         sif.step_done = 1;
         @(negedge clk) sif.step_done = 0;
         n_checks++;
         if (sif.script_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drop[%0d] got %b want 0", i, sif.script_valid); end
         if (i < 3) begin
            @(negedge clk);
            n_checks++;
            if (sif.script_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_early[%0d] got %b want 0", i, sif.script_valid); end
            @(negedge clk);
            n_checks++;
            if (sif.script_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_next[%0d] got %b want 1", i, sif.script_valid); end
         end
      end
      wait_halt(ok);
      n_checks++;
      if (!ok || sif.pc !== 8'd4) begin n_fail++; $display("FAIL b2b_halt got %b/%h want 1/04", ok, sif.pc); end
   endtask
   task automatic test_ignored();
      bit ok;
      clear_mem();
      mem[0] = 16'h0103;
      mem[1] = 16'h0301;
      exp_q.push_back(16'h0301);
      pulse_start();
      sif.step_done = 1;
      repeat (6) @(negedge clk);
      sif.step_done = 0;
      wait_valid(ok);
      n_checks++;
      if (!ok || sif.pc !== 8'd1) begin n_fail++; $display("FAIL ign_step_wait got %b/%h want 1/01", ok, sif.pc); end
      pulse_start();
      n_checks++;
      if ({sif.script_valid, sif.pc} !== {1'b1, 8'd1}) begin
         n_fail++; $display("FAIL ign_start got %b/%h want 1/01", sif.script_valid, sif.pc);
      end
      sif.step_done = 1;
      @(negedge clk) sif.step_done = 0;
      wait_halt(ok);
      @(negedge clk) sif.step_done = 1;
      @(negedge clk) sif.step_done = 0;
      @(negedge clk);
      n_checks++;
      if ({sif.halted, sif.pc} !== {1'b1, 8'd2}) begin
         n_fail++; $display("FAIL ign_step_halt got %b/%h want 1/02", sif.halted, sif.pc);
      end
   endtask
   task automatic test_watchdog();
      bit ok;
      int n;
      clear_mem();
      mem[0] = 16'h0301;
      exp_q.push_back(16'h0301);
      pulse_start();
      wait_valid(ok);
`ifdef SEQ_WATCHDOG_EN
      n = 0;
      while (sif.script_valid && n < 100) begin n++; @(negedge clk); end
      n_checks++;
      if (n != 16 || {sif.error, sif.halted} !== 2'b11) begin
         n_fail++; $display("FAIL wdog_trip got %0d/%b/%b want 16/1/1", n, sif.error, sif.halted);
      end
      exp_q.push_back(16'h0301);
      pulse_start();
      n_checks++;
      if (sif.error !== 1'b0) begin n_fail++; $display("FAIL wdog_clear got %b want 0", sif.error); end
      wait_valid(ok);
`else
      n = 40;
      repeat (n) @(negedge clk);
      n_checks++;
      if (!ok || {sif.script_valid, sif.error, sif.halted} !== 3'b100) begin
         n_fail++; $display("FAIL nowdog_hold got %b/%b/%b want 1/0/0", sif.script_valid, sif.error, sif.halted);
      end
`endif
      sif.step_done = 1;
      @(negedge clk) sif.step_done = 0;
      wait_halt(ok);
      n_checks++;
      if (!ok || sif.error !== 1'b0) begin n_fail++; $display("FAIL wdog_end got %b/%b want 1/0", ok, sif.error); end
   endtask
   task automatic test_rst_mid();
      bit ok;
      clear_mem();
      mem[0] = 16'h0301;
      exp_q.push_back(16'h0301);
      pulse_start();
      wait_valid(ok);
      rst = 1;
      #1;
      n_checks++;
      if (!ok || {sif.script_valid, sif.running, sif.halted, sif.pc, sif.script} !== 27'h0) begin
         n_fail++; $display("FAIL rst_async got %b/%b/%h/%h want 0/0/00/0000", sif.script_valid, sif.running, sif.pc, sif.script);
      end
      @(negedge clk) rst = 0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({sif.running, sif.script_valid} !== 2'b00) begin
         n_fail++; $display("FAIL rst_no_resume got %b/%b want 0/0", sif.running, sif.script_valid);
      end
   endtask
   initial begin
      test_reset();
      test_action();
      test_jump();
      test_wait_timed();
      test_wait_feedback();
      test_wrap();
      test_back_to_back();
      test_ignored();
      test_watchdog();
      test_rst_mid();
      n_checks++;
      if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain got %0d want 0", exp_q.size()); end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/script_sequencer.md
# script_sequencer

Program-counter stage directly upstream of the script analyser. Fetches 16-bit script words from the synchronous script memory, resolves jump and wait instructions locally, and hands action/game words to the analyser one at a time. The next word is issued only after the kitchen side reports the current step done.

## Interface
Parameters:
- ADDR_W, 8, script memory address width; PC width.
- WAIT_TICK, 100000, clock cycles per wait unit; minimum 1.
- WDOG_CYCLES, 2**24, dispatch timeout in cycles. Used only with SEQ_WATCHDOG_EN.

Ports:
- clk  in  1  system clock; all logic rises on posedge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; starts the program from address 0. Honoured only in IDLE or HALT.
- step_done  in  1  downstream finished executing the dispatched word.
- feedback_sig  in  1  kitchen state flag; used for conditional jumps and waits.
- mem_addr  out  ADDR_W  script memory read address; equals pc combinationally.
- mem_data  in  16  script memory read data; valid one cycle after the address.
- script  out  16  dispatched word; holds its value until the next dispatch.
- script_valid  out  1  high while a word awaits step_done.
- pc  out  ADDR_W  current program counter.
- running  out  1  high in every state except IDLE and HALT.
- halted  out  1  high in HALT.
- error  out  1  watchdog expiry flag; sticky until reset or start.

## Operation
- Word fields: i_num=[15:8], i_sign=[7:5], func=[4:3], op=[2:0].
- States: IDLE, FETCH, DECODE, DISPATCH, WAIT, HALT.
- IDLE/HALT + start: pc<=0, error<=0, go to FETCH.
- FETCH: address is on the bus; go to DECODE unconditionally.
- DECODE: sample mem_data, then branch on op:
  - 001 action / 100 game: script<=word; go to DISPATCH.
  - 010 jump: func=00 always taken; 01 taken if feedback_sig=1; 10 taken if feedback_sig=0; 11 never taken. Taken: pc<=i_num[ADDR_W-1:0]. Not taken: pc<=pc+1. Either way go to FETCH.
  - 011 wait: func=00 is a timed wait of i_num units (i_num=0 behaves as a NOP). func=01 waits until feedback_sig=1. func=1x is a NOP. Go to WAIT, or to FETCH with pc+1 for the NOP cases.
  - 000: go to HALT; pc is held.
  - 101-111: NOP; pc<=pc+1, go to FETCH.
- DISPATCH: script_valid=1. On step_done: pc<=pc+1, go to FETCH.
- WAIT:
  - Timed: a prescaler counts WAIT_TICK cycles per unit; the unit counter is loaded with i_num. When it reaches 0: pc<=pc+1, go to FETCH.
  - Conditional: when feedback_sig=1, pc<=pc+1, go to FETCH.
- pc+1 wraps from 2**ADDR_W-1 to 0. No halt on wrap.
- step_done outside DISPATCH is ignored.
- start outside IDLE/HALT is ignored.

## Timing
- Reset values: state=IDLE, pc=0, script=0, script_valid=0, running=0, halted=0, error=0, all counters=0.
- start sampled at edge k: FETCH in k+1, DECODE in k+2, script_valid=1 from k+3.
- step_done sampled at edge m: script_valid=0 from m+1; the next action word is valid at m+3 at the earliest.
- step_done in the first DISPATCH cycle is accepted.
- A jump or NOP costs 2 cycles (FETCH+DECODE) before the next DECODE.
- A timed wait of n units occupies WAIT for exactly n*WAIT_TICK cycles.
- feedback_sig is sampled in the DECODE cycle for jumps and in every WAIT cycle for conditional waits.
- rst asserted mid-operation: every output returns to its reset value immediately (asynchronous). The program does not resume; a new start is required.

## Configuration
- SEQ_WATCHDOG_EN defined:
  - A counter runs while in DISPATCH.
  - After WDOG_CYCLES cycles without step_done: error<=1, script_valid<=0, go to HALT.
  - The counter clears when DISPATCH is entered.
- SEQ_WATCHDOG_EN undefined: DISPATCH waits indefinitely; error is tied to 0; no counter is synthesised.

## Structure
- Shared package holds:
  - opcode constants: OP_END=000, OP_ACTION=001, OP_JUMP=010, OP_WAIT=011, OP_GAME=100;
  - jump func constants: JMP_ALWAYS, JMP_IF_SET, JMP_IF_CLR, JMP_NEVER;
  - the state enum;
  - field bit-range constants. The analyser uses the same opcodes.
- One sub-module: seq_wait_timer, containing the prescaler and unit counter. It has load/count/done ports and is instantiated once.

## Test plan
- Program {0:0x0301 action, 1:0x0000 end}, start pulse: script=0x0301 with script_valid at k+3; step_done at k+5 -> HALT, halted=1, pc=1.
- Jump word 0x0512 (func=10, i_num=5) at address 0: with feedback_sig=0, pc=5 at the following FETCH; with feedback_sig=1, pc=1.
- Wait word 0x0303 with WAIT_TICK=4: WAIT lasts exactly 12 cycles, then FETCH at address+1.
- Wait word 0x000B (wait on feedback): stays in WAIT until feedback_sig=1 is raised at cycle 20, then FETCH at the next cycle.
- pc=2**ADDR_W-1 holding a NOP: next fetch address is 0. rst pulse during DISPATCH: script_valid=0, script=0, state IDLE within the same cycle.
- With SEQ_WATCHDOG_EN and WDOG_CYCLES=16: no step_done -> error=1 and halted=1 after 16 DISPATCH cycles. A following start clears error.
